// File: rtl/ps_pl_pkg.sv
// Shared definitions for the FIFO-to-AXI-Stream packer slice.
//   - pk_state_e : packer state encoding (FILL collects lanes, SEND presents a beat)
//   - *_DEF      : default parameter values for the packer
package ps_pl_pkg;

  typedef enum logic {
    FILL = 1'b0,
    SEND = 1'b1
  } pk_state_e;

  localparam int SIZE_DEF        = 8;
  localparam int LANES_DEF       = 4;
  localparam int FRAME_BEATS_DEF = 16;

endpackage

// File: rtl/fifo_small.sv
// Small first-word-fall-through FIFO used as the cell source ahead of the packer.
// rd_data always shows the head cell; it is consumed on an edge with rd_en && valid.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   wr_en, wr_data  : push (ignored when full)
//   rd_en, rd_data  : pop request, head cell
//   valid, full     : not empty / full flags
//   count           : current occupancy
module fifo_small #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [SIZE-1:0]          wr_data,
  input  logic                     rd_en,
  output logic [SIZE-1:0]          rd_data,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            push, pop;

  assign valid   = (count != '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign push    = wr_en && !full;
  assign pop     = rd_en && valid;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/fifo_axis_packer.sv
// Packs SIZE-bit FIFO cells into LANES-wide AXI-Stream beats.
// Lanes fill LSB-first; a full beat or a flush moves to SEND, where the beat is
// held until the downstream handshake. tlast marks the FRAME_BEATS-th beat of a
// frame or any flush beat; frames_sent counts completed frames.
// Ports:
//   clk, rst_n                  : clock, async active-low reset
//   fifo_valid/fifo_enr/fifo_data : upstream FIFO (data valid when enr && valid)
//   flush                       : close the current frame early (partial beat)
//   m_axis_*                    : AXI-Stream master, registered outputs
//   frames_sent                 : completed frame counter, wraps
module fifo_axis_packer
  import ps_pl_pkg::*;
#(
  parameter int SIZE        = SIZE_DEF,
  parameter int LANES       = LANES_DEF,
  parameter int FRAME_BEATS = FRAME_BEATS_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fifo_valid,
  output logic                    fifo_enr,
  input  logic [SIZE-1:0]         fifo_data,
  input  logic                    flush,
  output logic [SIZE*LANES-1:0]   m_axis_tdata,
  output logic [LANES-1:0]        m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [15:0]             frames_sent
);
  localparam int LW = $clog2(LANES);
  localparam int BW = $clog2(FRAME_BEATS);

  pk_state_e       state;
  logic [LW-1:0]   lane_idx;
  logic [BW-1:0]   beat_idx;

  logic            pop, last_lane, flush_go, close, frame_end;
  logic [LW:0]     n_fill;
  logic [LANES-1:0] keep_nxt;

  // Pops only happen while collecting; SEND stalls the FIFO.
  assign fifo_enr = fifo_valid && (state == FILL);

  always_comb begin
    pop       = fifo_enr;
    last_lane = (lane_idx == LW'(LANES-1));
    frame_end = (beat_idx == BW'(FRAME_BEATS-1));
    // A flush only closes a beat that will hold at least one cell.
    flush_go  = flush && ((lane_idx != '0) || pop);
    close     = (pop && last_lane) || flush_go;
    // Lanes filled after this edge, counting a same-cycle pop.
    n_fill    = {1'b0, lane_idx} + {{LW{1'b0}}, pop};
    keep_nxt  = '0;
    for (int i = 0; i < LANES; i++) keep_nxt[i] = ((LW+1)'(i) < n_fill);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= FILL;
      lane_idx      <= '0;
      beat_idx      <= '0;
      frames_sent   <= '0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (pop) begin
            m_axis_tdata[lane_idx*SIZE +: SIZE] <= fifo_data;
            lane_idx <= lane_idx + LW'(1);  // wraps to 0 after the last lane
          end
          if (close) begin
            state         <= SEND;
            m_axis_tvalid <= 1'b1;
            m_axis_tkeep  <= keep_nxt;
            m_axis_tlast  <= flush_go || frame_end;
          end
        end
        SEND: begin
          // Flush is ignored here; the beat is held until accepted.
          if (m_axis_tready) begin
            state         <= FILL;
            lane_idx      <= '0;
            m_axis_tdata  <= '0;  // unfilled lanes of the next flush beat read zero
            m_axis_tkeep  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            if (m_axis_tlast) begin
              beat_idx    <= '0;
              frames_sent <= frames_sent + 16'd1;
            end else begin
              beat_idx    <= beat_idx + BW'(1);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_axis_packer.sv
module tb_fifo_axis_packer;
  localparam int SIZE  = 8;
  localparam int LANES = 4;
  localparam int FB    = 2;

  logic        clk = 1'b0;
  logic        rst_n, wr_en, flush, tready;
  logic [7:0]  wr_data, fifo_data;
  logic        fifo_valid, fifo_enr, full;
  logic [4:0]  count;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid, tlast;
  logic [15:0] frames_sent;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_small #(.SIZE(SIZE), .DEPTH(16)) u_fifo (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(fifo_enr), .rd_data(fifo_data), .valid(fifo_valid),
    .full(full), .count(count)
  );

  fifo_axis_packer #(.SIZE(SIZE), .LANES(LANES), .FRAME_BEATS(FB)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_valid(fifo_valid), .fifo_enr(fifo_enr),
    .fifo_data(fifo_data), .flush(flush), .m_axis_tdata(tdata),
    .m_axis_tkeep(tkeep), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tlast(tlast), .frames_sent(frames_sent)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Transaction-level model: a list of captured cells and one pending beat.
  logic [7:0]  m_cur[$];
  bit          m_busy = 0;
  logic [31:0] m_data = '0;
  logic [3:0]  m_keep = '0;
  bit          m_last = 0;
  int          m_beat = 0;
  int          m_frames = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cur.delete();
      m_busy = 0; m_data = '0; m_keep = '0; m_last = 0; m_beat = 0; m_frames = 0;
    end else if (m_busy) begin
      if (tready) begin
        m_busy = 0;
        if (m_last) begin m_beat = 0; m_frames = (m_frames + 1) % 65536; end
        else m_beat++;
      end
    end else begin
      if (fifo_valid) m_cur.push_back(fifo_data);
      if (m_cur.size() == LANES || (flush && m_cur.size() > 0)) begin
        m_data = '0;
        foreach (m_cur[i]) m_data = m_data | (32'(m_cur[i]) << (8 * i));
        m_keep = 4'((1 << m_cur.size()) - 1);
        m_last = flush || (m_beat == FB - 1);
        m_cur.delete();
        m_busy = 1;
      end
    end
  end

  // Accepted beats as seen on the bus, for the literal checks.
  typedef struct packed { logic [31:0] d; logic [3:0] k; logic l; } beat_t;
  beat_t hs_q[$];
  always @(posedge clk) begin
    if (rst_n && tvalid && tready) hs_q.push_back('{d: tdata, k: tkeep, l: tlast});
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("enr", fifo_enr, fifo_valid && !m_busy);
    chk("tvalid", tvalid, m_busy);
    chk("frames", frames_sent, 16'(m_frames));
    if (m_busy) begin
      chk("tdata", tdata, m_data);
      chk("tkeep", tkeep, m_keep);
      chk("tlast", tlast, m_last);
    end else begin
      chk("tkeep_idle", tkeep, 0);
      chk("tlast_idle", tlast, 0);
    end
    if (!rst_n) chk("tdata_rst", tdata, 0);
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d; tick(); wr_en = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  task automatic wait_hs(input int n, input string nm);
    int k = 0;
    while (hs_q.size() < n && k < 300) begin tick(); k++; end
    chk({nm, "_hs_timeout"}, 64'(hs_q.size() >= n), 1);
  endtask

  task automatic wait_empty(input string nm);
    int k = 0;
    while (count != 0 && k < 100) begin tick(); k++; end
    chk({nm, "_drain_timeout"}, count, 0);
  endtask

  task automatic check_beat(input int idx, input logic [31:0] d, input logic [3:0] kp,
                            input logic l, input string nm);
    if (idx < hs_q.size()) begin
      chk({nm, "_data"}, hs_q[idx].d, d);
      chk({nm, "_keep"}, hs_q[idx].k, kp);
      chk({nm, "_last"}, hs_q[idx].l, l);
    end else begin
      chk({nm, "_missing"}, 0, 1);
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; flush = 1'b0; tready = 1'b1;
    tick(); tick();
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tkeep", tkeep, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_frames", frames_sent, 0);
    chk("rst_enr", fifo_enr, 0);
    rst_n = 1'b1; tick();

    // Full frame of two beats.
    for (int i = 1; i <= 8; i++) push(8'(i));
    wait_hs(2, "t1");
    check_beat(0, 32'h04030201, 4'hF, 1'b0, "t1_b0");
    check_beat(1, 32'h08070605, 4'hF, 1'b1, "t1_b1");
    tick();
    chk("t1_frames", frames_sent, 1);

    // Backpressure: beat held, no pops, flush in SEND ignored.
    hs_q.delete();
    tready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'h11 + 8'(i));
    begin
      int k = 0;
      while (!tvalid && k < 50) begin tick(); k++; end
    end
    for (int i = 0; i < 10; i++) begin
      flush = (i == 3);
      chk("bp_tdata", tdata, 32'h14131211);
      chk("bp_tkeep", tkeep, 4'hF);
      chk("bp_tlast", tlast, 0);
      chk("bp_enr", fifo_enr, 0);
      chk("bp_count", count, 2);
      tick();
    end
    flush = 1'b0;
    tready = 1'b1;
    wait_hs(1, "t2a");
    check_beat(0, 32'h14131211, 4'hF, 1'b0, "t2_b0");
    wait_empty("t2");
    tick();
    pulse_flush();
    wait_hs(2, "t2b");
    check_beat(1, 32'h00001615, 4'h3, 1'b1, "t2_b1");
    tick();
    chk("t2_frames", frames_sent, 2);

    // Partial flush, then the next frame starts at beat 0.
    hs_q.delete();
    push(8'hAA); push(8'hBB); push(8'hCC);
    wait_empty("t3");
    pulse_flush();
    wait_hs(1, "t3a");
    check_beat(0, 32'h00CCBBAA, 4'h7, 1'b1, "t3_flush");
    for (int i = 1; i <= 4; i++) push(8'(i));
    wait_hs(2, "t3b");
    check_beat(1, 32'h04030201, 4'hF, 1'b0, "t3_next");
    for (int i = 5; i <= 8; i++) push(8'(i));
    wait_hs(3, "t3c");
    check_beat(2, 32'h08070605, 4'hF, 1'b1, "t3_end");
    tick();
    chk("t3_frames", frames_sent, 4);

    // Flush together with the pop of the fourth cell, at beat 0.
    hs_q.delete();
    push(8'h11); push(8'h22); push(8'h33);
    wait_empty("t4");
    wr_en = 1'b1; wr_data = 8'h44; tick(); wr_en = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    wait_hs(1, "t4");
    check_beat(0, 32'h44332211, 4'hF, 1'b1, "t4");
    tick();
    chk("t4_frames", frames_sent, 5);

    // Empty flush does nothing.
    repeat (2) tick();
    pulse_flush();
    repeat (5) begin
      chk("t5_tvalid", tvalid, 0);
      tick();
    end
    chk("t5_hs", hs_q.size(), 1);
    chk("t5_frames", frames_sent, 5);

    // Reset mid-FILL discards the partial beat.
    hs_q.delete();
    push(8'h55); push(8'h66);
    wait_empty("t6");
    tick();
    rst_n = 1'b0; tick();
    chk("t6_rst_tdata", tdata, 0);
    chk("t6_rst_frames", frames_sent, 0);
    tick();
    rst_n = 1'b1; tick();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    wait_hs(1, "t6");
    check_beat(0, 32'h44332211, 4'hF, 1'b0, "t6");
    tick();
    chk("t6_frames", frames_sent, 0);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_axis_packer.md
FIFO_AXIS_PACKER -- requirements
Module: fifo_axis_packer

Interface
REQ-001 SHALL have parameter SIZE, default 8, width in bits of one FIFO cell (one lane).
REQ-002 SHALL have parameter LANES, default 4, lanes per output beat; power of two, at least 2.
REQ-003 SHALL have parameter FRAME_BEATS, default 16, beats per frame before automatic tlast; at least 2.
REQ-004 SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port fifo_valid, input, 1, upstream FIFO not empty.
REQ-007 SHALL have port fifo_enr, output, 1, pop request to the FIFO.
REQ-008 SHALL have port fifo_data, input, SIZE, popped cell; valid only in a cycle with fifo_enr and fifo_valid both high.
REQ-009 SHALL have port flush, input, 1, single-cycle request to close the current frame early.
REQ-010 SHALL have port m_axis_tdata, output, SIZE*LANES, packed beat.
REQ-011 SHALL have port m_axis_tkeep, output, LANES, one bit per valid lane.
REQ-012 SHALL have port m_axis_tvalid, output, 1, beat available.
REQ-013 SHALL have port m_axis_tready, input, 1, downstream accepts the beat.
REQ-014 SHALL have port m_axis_tlast, output, 1, last beat of the frame.
REQ-015 SHALL have port frames_sent, output, 16, count of completed frames; wraps at 65535 to 0.

Function
REQ-016 SHALL implement two states: FILL (collect lanes) and SEND (present beat).
REQ-017 SHALL drive fifo_enr = fifo_valid AND (state == FILL) as a combinational output.
REQ-018 SHALL, on each edge with fifo_enr high, capture fifo_data into lane index lane_idx at bits [lane_idx*SIZE +: SIZE] (lane 0 = LSBs) and increment lane_idx.
REQ-019 SHALL go to SEND with tkeep all ones when lane LANES-1 is captured.
REQ-020 SHALL, on flush in FILL: if lane_idx > 0 or a pop occurs in the same cycle, go to SEND with tlast=1.
REQ-021 SHALL, for such a flush beat, set tkeep bits [0..n-1] where n is the number of lanes filled including any same-cycle pop; unfilled lanes of tdata SHALL be zero.
REQ-022 SHALL ignore flush in FILL when lane_idx == 0 and no pop occurs; SHALL ignore flush in SEND.
REQ-023 SHALL assert tvalid throughout SEND and SHALL hold tdata, tkeep and tlast stable until tready is sampled high.
REQ-024 SHALL, on the edge with tvalid and tready both high, return to FILL, clear lane_idx and the lane registers, and clear tkeep.
REQ-025 SHALL assert tlast when beat_idx == FRAME_BEATS-1 or when the beat is a flush beat.
REQ-026 SHALL, on each handshake, set beat_idx to 0 if tlast is high and otherwise increment it; SHALL increment frames_sent on each handshake with tlast high.
REQ-027 SHALL require LANES+1 cycles minimum per beat; no pop SHALL occur in SEND.
REQ-028 SHALL size lane_idx at $clog2(LANES) bits and beat_idx at $clog2(FRAME_BEATS) bits.

Reset
REQ-029 SHALL, while rst_n is low, force: state FILL; lane_idx, beat_idx, lane registers and frames_sent to 0; tvalid, tlast, tkeep and tdata to 0.
REQ-030 SHALL, on reset mid-operation, discard any partial beat, so the next captured byte lands in lane 0 of beat 0.

Structure
REQ-031 SHALL take the state encoding (FILL=0, SEND=1) and the default parameter constants from shared package ps_pl_pkg.
REQ-032 SHALL contain no RTL sub-module; the bench SHALL instantiate fifo_small (SIZE=8) upstream as the stimulus source.

Verification (LANES=4, FRAME_BEATS=2, SIZE=8)
REQ-033 SHALL test a full frame: push 01..08, tready=1 -> beats 0x04030201 (tkeep F, tlast 0) then 0x08070605 (tkeep F, tlast 1); frames_sent=1.
REQ-034 SHALL test backpressure: tready=0 for 10 cycles in SEND -> tdata/tkeep/tlast stable, fifo_enr=0, FIFO occupancy unchanged.
REQ-035 SHALL test a partial flush: push AA BB CC, pulse flush -> tdata 0x00CCBBAA, tkeep 7, tlast 1; next beat starts at beat_idx 0.
REQ-036 SHALL test flush with a same-cycle 4th pop: push 11 22 33, then flush together with the pop of 44 -> 0x44332211, tkeep F, tlast 1.
REQ-037 SHALL test an empty flush: flush with lane_idx=0 and FIFO empty -> tvalid stays 0, frames_sent unchanged.
REQ-038 SHALL test reset mid-FILL: after 2 bytes captured, pulse rst_n low, then push 11 22 33 44 -> first beat 0x44332211, tlast 0.
